// File: rtl/uart_pkg.sv
// uart_pkg: shared widths and types for the UART receive buffer.
//   DW          byte width received from the UART
//   WW          width of a buffered entry, which is also the Hack word width
//   uart_byte_t one received byte
//   uart_word_t one FIFO entry
package uart_pkg;

  localparam int DW = 8;
  localparam int WW = 16;

  typedef logic [DW-1:0] uart_byte_t;
  typedef logic [WW-1:0] uart_word_t;

endpackage

// File: rtl/uart_fifo_core.sv
// uart_fifo_core: circular FIFO with register-based storage, used as the
// storage behind the UART receive buffer. A push is offered every cycle that
// push=1. It is accepted unless the FIFO is full with no pop in the same
// cycle, and the caller decides what a refused push means.
//
// Ports:
//   clk, rstn  clock and asynchronous active-low reset
//   push       entry offered this cycle
//   wr_data    entry to store
//   rdy        consumer accepts the head entry
//   vld        head entry available (count != 0)
//   rd_data    head entry
//   count      stored entries, 0..DEPTH
//   full       count == DEPTH
//   pop        head consumed this cycle (vld & rdy)
module uart_fifo_core
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = WW,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic [W-1:0]  wr_data,
  input  logic          rdy,
  output logic          vld,
  output logic [W-1:0]  rd_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          pop
);

  // The pointers are one bit wider than the index. Equal indices with
  // different MSBs mean the FIFO is full, and equal pointers mean it is empty.
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic         accept;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign vld     = (wr_ptr_q != rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop     = vld & rdy;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // When the FIFO is full, a pop in the same cycle frees the head slot, so
  // the write lands in the slot being vacated. The head entry is never
  // overwritten while it is still visible.
  assign accept  = push & (~full | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (accept) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) mem_q[gi] <= '0;
        else       mem_q[gi] <= mem_d[gi];
      end
    end
  endgenerate

endmodule

// File: rtl/uart_rx_buf.sv
// uart_rx_buf: receive-side buffer placed after the UART receiver. It captures
// single-cycle byte strobes, which cannot be stalled, into a FIFO and presents
// them through a valid/ready interface. A push that arrives while the FIFO is
// full is dropped and sets a sticky overflow flag.
//
// Build option: define UART_RX_BUF_WORD_EN to pack byte pairs into 16-bit
// little-endian words, with the first byte low, before buffering. Without the
// macro, each byte is buffered zero-extended and half is tied to 0.
//
// Ports:
//   clk, rstn        clock and asynchronous active-low reset
//   in_vld, in_dat   byte strobe and data from the UART receiver
//   out_vld, out_rdy head-entry handshake
//   out_dat          head entry
//   count            stored entries, 0..DEPTH
//   half             packer holds a pending low byte
//   ovf, ovf_clr     sticky overflow flag and its clear
module uart_rx_buf
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_vld,
  input  logic [7:0]    in_dat,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [15:0]   out_dat,
  output logic [AW:0]   count,
  output logic          half,
  output logic          ovf,
  input  logic          ovf_clr
);

  logic       push;
  uart_word_t push_dat;
  logic       full;
  logic       pop;
  logic       drop;
  logic       ovf_q, ovf_d;

`ifdef UART_RX_BUF_WORD_EN
  logic       half_q, half_d;
  uart_byte_t lo_q, lo_d;

  // The first byte of a pair is parked in the pack register. The second byte
  // releases the whole word, and the pair is complete even if that word is
  // then dropped.
  always_comb begin
    half_d   = half_q;
    lo_d     = lo_q;
    push     = in_vld & half_q;
    push_dat = {in_dat, lo_q};
    if (in_vld) begin
      if (half_q) begin
        half_d = 1'b0;
      end else begin
        half_d = 1'b1;
        lo_d   = in_dat;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      half_q <= 1'b0;
      lo_q   <= '0;
    end else begin
      half_q <= half_d;
      lo_q   <= lo_d;
    end
  end

  assign half = half_q;
`else
  always_comb begin
    push     = in_vld;
    push_dat = {{(WW-DW){1'b0}}, in_dat};
  end

  assign half = 1'b0;
`endif

  uart_fifo_core #(
    .DEPTH (DEPTH),
    .W     (WW)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push    (push),
    .wr_data (push_dat),
    .rdy     (out_rdy),
    .vld     (out_vld),
    .rd_data (out_dat),
    .count   (count),
    .full    (full),
    .pop     (pop)
  );

  // A dropped push takes priority over a clear in the same cycle, so an
  // overflow is never lost.
  assign drop = push & full & ~pop;

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;

endmodule
